// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants and types used by the register file and its
// write scoreboard.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

    // Hard-wired zero register index.
    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/cpu_scoreboard.sv
// cpu_scoreboard: per-register outstanding-write counters.
// A claim from decode increments the destination counter, a writeback
// release decrements it (clamped at 0, flagging underflow). Register 0 never
// counts. Exports per-register busy and saturation vectors.
module cpu_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int PEND_W = 2,
    parameter bit BYPASS = 1'b0
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_claim,
    input  logic [ADDR_W-1:0]      i_claim_reg,
    input  logic                   i_rel,
    input  logic [ADDR_W-1:0]      i_rel_reg,
    output logic [2**ADDR_W-1:0]   o_busy,
    output logic [2**ADDR_W-1:0]   o_sat,
    output logic                   o_underflow
);

    localparam int                NREG   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LP_ZERO = ADDR_W'(REG_ZERO);
    localparam logic [PEND_W-1:0] LP_MAX  = '1;
    localparam logic [PEND_W-1:0] LP_ONE  = PEND_W'(1);

    logic [PEND_W-1:0] r_cnt     [NREG];
    logic [PEND_W-1:0] w_cnt_nxt [NREG];
    logic [NREG-1:0]   w_claim_hit;
    logic [NREG-1:0]   w_rel_hit;
    logic              w_claim_en;
    logic              w_rel_en;
    logic              w_uf_set;
    logic              r_underflow;

    // Register 0 is excluded here so its counter can never move.
    assign w_claim_en = i_claim && (i_claim_reg != LP_ZERO);
    assign w_rel_en   = i_rel   && (i_rel_reg   != LP_ZERO);

    // Next-count arithmetic: a simultaneous claim and release on one register cancel out.
    always_comb begin
        w_uf_set    = 1'b0;
        w_claim_hit = '0;
        w_rel_hit   = '0;
        for (int i = 0; i < NREG; i++) begin
            w_claim_hit[i] = w_claim_en && (i_claim_reg == ADDR_W'(i)) && (r_cnt[i] != LP_MAX);
            w_rel_hit[i]   = w_rel_en   && (i_rel_reg   == ADDR_W'(i));
            w_cnt_nxt[i]   = r_cnt[i];
            if (w_claim_hit[i] && !w_rel_hit[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + LP_ONE;
            end else if (!w_claim_hit[i] && w_rel_hit[i]) begin
                if (r_cnt[i] != '0) begin
                    w_cnt_nxt[i] = r_cnt[i] - LP_ONE;
                end else begin
                    w_uf_set = 1'b1;
                end
            end
        end
    end

    // Counter and sticky underflow state; reset discards all pending claims.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (w_uf_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Busy/saturation views; with bypass, a register whose last write is retiring now is not busy.
    always_comb begin
        o_busy = '0;
        o_sat  = '0;
        for (int i = 0; i < NREG; i++) begin
            o_busy[i] = (r_cnt[i] != '0) &&
                        !(BYPASS && w_rel_hit[i] && (r_cnt[i] == LP_ONE));
            o_sat[i]  = (r_cnt[i] == LP_MAX);
        end
    end

    assign o_underflow = r_underflow;

endmodule

// File: rtl/cpu_regfile_scoreboard.sv
// cpu_regfile_scoreboard: register file with per-register write scoreboard.
// Responds to decode's register reads (combinational data + stall) and
// accepts claims from decode and releases/data from writeback.
// Optional feature macro: REGFILE_BYPASS_EN -- forwards the writeback value
// to a same-cycle read and releases the stall on the retiring last write.
module cpu_regfile_scoreboard #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int PEND_W = 2
)(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] reg_s,
    input  logic [ADDR_W-1:0] reg_t,
    input  logic [ADDR_W-1:0] reg_id_d,
    input  logic              reg_claim,
    output logic              claim_ready,
    output logic [DATA_W-1:0] reg_s_data,
    output logic [DATA_W-1:0] reg_t_data,
    output logic              reg_stall,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              sb_underflow
);

    localparam int                NREG    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LP_ZERO = ADDR_W'(cpu_pkg::REG_ZERO);
`ifdef REGFILE_BYPASS_EN
    localparam bit LP_BYPASS = 1'b1;
`else
    localparam bit LP_BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] r_mem [NREG];
    logic [NREG-1:0]   w_busy;
    logic [NREG-1:0]   w_sat;
    logic              w_wb_en;
    logic              w_underflow;

    // A write during the reset cycle must not land or forward.
    assign w_wb_en = wb_valid && !reset && (wb_reg != LP_ZERO);

    cpu_scoreboard #(
        .ADDR_W (ADDR_W),
        .PEND_W (PEND_W),
        .BYPASS (LP_BYPASS)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .i_claim     (reg_claim),
        .i_claim_reg (reg_id_d),
        .i_rel       (wb_valid && !reset),
        .i_rel_reg   (wb_reg),
        .o_busy      (w_busy),
        .o_sat       (w_sat),
        .o_underflow (w_underflow)
    );

    // Data array: cleared on reset, written by writeback (register 0 stays 0).
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wb_en) begin
            r_mem[wb_reg] <= wb_data;
        end
    end

    // Read muxes, with optional forwarding of the value being written back this cycle.
    always_comb begin
        reg_s_data = (reg_s == LP_ZERO) ? '0 : r_mem[reg_s];
        reg_t_data = (reg_t == LP_ZERO) ? '0 : r_mem[reg_t];
        if (LP_BYPASS && w_wb_en && (wb_reg == reg_s)) begin
            reg_s_data = wb_data;
        end
        if (LP_BYPASS && w_wb_en && (wb_reg == reg_t)) begin
            reg_t_data = wb_data;
        end
    end

    // Register 0 is never busy, so no extra masking is needed on the sources.
    assign reg_stall    = w_busy[reg_s] | w_busy[reg_t];
    assign claim_ready  = (reg_id_d == LP_ZERO) || !w_sat[reg_id_d];
    assign sb_underflow = w_underflow;

endmodule
